rsp_s2_prep_phase_sched: RTL

- Controller for the S2-prep phase-generation datapath.
- Streams the 32-entry phase table (base[31:16], step[15:0]) from the host into the phase generator's entry-RAM write port, in order.
- Then runs frames: for each accepted request it presents the entry select and 16/32 mode, waits for the entry-RAM read to settle, pulses start, and emits a valid/last beat stream honouring downstream backpressure.

---
 rtl/rsp_s2_prep_phase_sched_if.sv | 43 ++++
 rtl/rsp_s2_prep_phase_sched.sv | 116 +++++++++++
 2 files changed

// File: rtl/rsp_s2_prep_phase_sched_if.sv
// Host/datapath bundle for the S2-prep phase scheduler.
// Carries table writes, frame requests, downstream ready and the phase-generator controls.
interface rsp_s2_prep_phase_sched_if #(
  parameter int ENTRY_W = 5,
  parameter int CNT_W   = 11
);
  logic               cfg_wr;
  logic [31:0]        cfg_wdata;
  logic               cfg_err;
  logic               loaded;
  logic               frm_req_valid;
  logic               frm_req_ready;
  logic [ENTRY_W-1:0] frm_entry;
  logic               frm_sel_16_32;
  logic [CNT_W-1:0]   frm_len;
  logic               ds_ready;
  logic               pg_ram1_ena;
  logic               pg_ram1_wena;
  logic [31:0]        pg_ram1_dina;
  logic [ENTRY_W-1:0] pg_entry_select;
  logic               pg_sel_16_32;
  logic               pg_start;
  logic               pg_data_valid;
  logic               pg_data_last;
  logic               frm_done;
  logic               busy;

  // Scheduler side.
  modport slave (
    input  cfg_wr, cfg_wdata, frm_req_valid, frm_entry, frm_sel_16_32, frm_len, ds_ready,
    output cfg_err, loaded, frm_req_ready, pg_ram1_ena, pg_ram1_wena, pg_ram1_dina,
           pg_entry_select, pg_sel_16_32, pg_start, pg_data_valid, pg_data_last,
           frm_done, busy
  );

  // Host / stimulus side.
  modport master (
    output cfg_wr, cfg_wdata, frm_req_valid, frm_entry, frm_sel_16_32, frm_len, ds_ready,
    input  cfg_err, loaded, frm_req_ready, pg_ram1_ena, pg_ram1_wena, pg_ram1_dina,
           pg_entry_select, pg_sel_16_32, pg_start, pg_data_valid, pg_data_last,
           frm_done, busy
  );
endinterface

// File: rtl/rsp_s2_prep_phase_sched.sv
// S2-prep phase scheduler: loads the 32-entry phase table into the generator's
// auto-incrementing entry RAM, then sequences frames (select, settle, start, beats).
module rsp_s2_prep_phase_sched #(
  parameter int ENTRY_NUM  = 32,
  parameter int ENTRY_W    = 5,
  parameter int DATA_NUM   = 1024,
  parameter int CNT_W      = 11,
  parameter int SETTLE_CYC = 3
) (
  input logic clk,
  input logic rst,
  rsp_s2_prep_phase_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [ENTRY_W:0]   wr_cnt;
  logic               loaded_q;
  logic [3:0]         settle_cnt;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   len_m1;
  logic [ENTRY_W-1:0] entry_q;
  logic               sel_q;
  logic               ready_c;
  logic               accept;
  logic               beat_fire;
  logic               last_beat;

  assign ready_c   = loaded_q && (state == S_IDLE);
  assign accept    = ready_c && bus.frm_req_valid;
  assign beat_fire = (state == S_RUN) && bus.ds_ready;
  assign last_beat = beat_fire && (beat_cnt == len_m1);

  // Table load: one RAM write per accepted cfg_wr; extra writes after load raise cfg_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt            <= '0;
      loaded_q          <= 1'b0;
      bus.pg_ram1_ena   <= 1'b0;
      bus.pg_ram1_wena  <= 1'b0;
      bus.pg_ram1_dina  <= '0;
      bus.cfg_err       <= 1'b0;
    end else begin
      bus.pg_ram1_ena  <= bus.cfg_wr && !loaded_q;
      bus.pg_ram1_wena <= bus.cfg_wr && !loaded_q;
      bus.cfg_err      <= bus.cfg_wr && loaded_q;
      if (bus.cfg_wr && !loaded_q) begin
        bus.pg_ram1_dina <= bus.cfg_wdata;
        wr_cnt           <= wr_cnt + 1'b1;
        if (wr_cnt == (ENTRY_W+1)'(ENTRY_NUM-1)) loaded_q <= 1'b1;
      end
    end
  end

  // Frame parameters latched at accept; select/mode stay put until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q    <= '0;
      sel_q      <= 1'b0;
      len_m1     <= '0;
      settle_cnt <= '0;
      beat_cnt   <= '0;
    end else begin
      if (accept) begin
        entry_q    <= bus.frm_entry;
        sel_q      <= bus.frm_sel_16_32;
        len_m1     <= (bus.frm_len == '0) ? CNT_W'(DATA_NUM-1) : bus.frm_len - CNT_W'(1);
        settle_cnt <= 4'(SETTLE_CYC);
        beat_cnt   <= '0;
      end else begin
        if (state == S_SETTLE) settle_cnt <= settle_cnt - 4'd1;
        if (beat_fire) beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: settle for SETTLE_CYC cycles, one start cycle, beats until the last, one done cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == 4'd1) state_nxt = S_START;
      S_START:  state_nxt = S_RUN;
      S_RUN:    if (last_beat) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; valid is ds_ready gated by RUN so no beat is lost or repeated.
  always_comb begin
    bus.frm_req_ready   = ready_c;
    bus.pg_start        = (state == S_START);
    bus.pg_data_valid   = beat_fire;
    bus.pg_data_last    = last_beat;
    bus.frm_done        = (state == S_DONE);
    bus.busy            = (state != S_IDLE);
    bus.loaded          = loaded_q;
    bus.pg_entry_select = entry_q;
    bus.pg_sel_16_32    = sel_q;
  end

endmodule
